sa_adc_uart_tx: RTL and testbench



---
 rtl/sa_adc_uart_tx_if.sv | 28 ++
 rtl/sa_adc_uart_tx.sv | 125 ++++++++++++
 tb/tb_sa_adc_uart_tx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_adc_uart_tx_if.sv
// ADC-sample to UART serialiser port bundle.
// master drives samples and observes the line; slave is the serialiser.
interface sa_adc_uart_tx_if;
  logic [13:0] sample_i;
  logic        sample_rdy_i;
  logic        uart_tx_o;
  logic        busy_o;
  logic        frame_done_o;
  logic [7:0]  overrun_cnt_o;

  modport master (
    output sample_i,
    output sample_rdy_i,
    input  uart_tx_o,
    input  busy_o,
    input  frame_done_o,
    input  overrun_cnt_o
  );

  modport slave (
    input  sample_i,
    input  sample_rdy_i,
    output uart_tx_o,
    output busy_o,
    output frame_done_o,
    output overrun_cnt_o
  );
endinterface

// File: rtl/sa_adc_uart_tx.sv
// Packs a 14-bit ADC sample into a two-byte self-syncing frame
// and shifts it out as 8N1 UART; samples arriving mid-frame are counted.
module sa_adc_uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic              clk_i,
  input  logic              reset_i,
  sa_adc_uart_tx_if.slave   bus
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic          byte_q, byte_d;
  logic [13:0]   hold_q, hold_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic [7:0]    ovr_q, ovr_d;

  logic [7:0]    cur;
  logic [2:0]    bit_nx;
  logic          tick;

  always_comb begin
    cur     = byte_q ? {1'b0, hold_q[6:0]}
                     : {1'b1, hold_q[13:7]};
    bit_nx  = bit_q + 3'd1;
    tick    = (tmr_q == T_LAST);
    state_d = state_q;
    tmr_d   = tick ? '0 : tmr_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    hold_d  = hold_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;

    // any pulse outside IDLE is a dropped sample
    if (bus.sample_rdy_i && state_q != IDLE
        && ovr_q != 8'hFF) begin
      ovr_d = ovr_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (bus.sample_rdy_i) begin
          state_d = START;
          hold_d  = bus.sample_i;
          byte_d  = 1'b0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = cur[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nx;
            tx_d  = cur[bit_nx];
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (!byte_q) begin
            state_d = START;
            byte_d  = 1'b1;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 1'b0;
      hold_q  <= 14'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      ovr_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.uart_tx_o     = tx_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.frame_done_o  = done_q;
  assign bus.overrun_cnt_o = ovr_q;

endmodule

// File: tb/tb_sa_adc_uart_tx.sv
// Scoreboard bench for sa_adc_uart_tx: a line-level UART receiver
// and a frame-timing model check the serialised output.
module tb_sa_adc_uart_tx;
  localparam int C  = 4;
  localparam int FB = 20 * C;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sa_adc_uart_tx_if bus();

  sa_adc_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_b[$];
  int         exp_t[$];
  int         exp_done[$];
  logic [7:0] rx_log[$];

  int busy_start = 0;
  int busy_end   = 0;
  int ovr_m      = 0;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // one input cycle; the model decides accept vs overrun from frame timing
  task automatic drive(input logic rdy, input logic [13:0] s);
    int e;
    @(negedge clk);
    bus.sample_rdy_i = rdy;
    bus.sample_i     = s;
    if (rdy) begin
      e = cyc + 1;
      if (e > busy_end) begin
        busy_start = e;
        busy_end   = e + FB;
        exp_b.push_back({1'b1, s[13:7]});
        exp_t.push_back(e);
        exp_b.push_back({1'b0, s[6:0]});
        exp_t.push_back(e + 10 * C);
        exp_done.push_back(busy_end);
      end else if (ovr_m < 255) begin
        ovr_m++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 14'($urandom));
  endtask

  task automatic pulse(input logic [13:0] s);
    drive(1'b1, s);
    drive(1'b0, 14'($urandom));
  endtask

  task automatic goto_cyc(input int t);
    while (cyc + 1 < t) drive(1'b0, 14'($urandom));
  endtask

  task automatic wait_done();
    while (cyc < busy_end + 2) drive(1'b0, 14'($urandom));
  endtask

  task automatic chk_log(string name, input logic [7:0] b0,
                         input logic [7:0] b1);
    chk({name, "_len"}, rx_log.size(), 2);
    if (rx_log.size() == 2) begin
      chk({name, "_b0"}, int'(rx_log[0]), int'(b0));
      chk({name, "_b1"}, int'(rx_log[1]), int'(b1));
    end
    rx_log.delete();
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", int'(bus.uart_tx_o), 1);
    chk("rst_busy", int'(bus.busy_o), 0);
    exp_b.delete();
    exp_t.delete();
    exp_done.delete();
    rx_log.delete();
    busy_start = 0;
    busy_end   = 0;
    ovr_m      = 0;
    idle(3);
    chk("rst_done", int'(bus.frame_done_o), 0);
    chk("rst_ovr", int'(bus.overrun_cnt_o), 0);
    #1 rst = 1'b0;
  endtask

  // line receiver: every bit must hold one level for exactly C samples
  initial begin : rx
    int t0;
    logic ok;
    logic abort;
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (!rst && bus.uart_tx_o === 1'b0) begin
        t0    = cyc;
        ok    = 1'b1;
        abort = 1'b0;
        bits  = '0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int s = 0; s < C && !abort; s++) begin
            if (b != 0 || s != 0) begin
              @(negedge clk);
              if (rst) abort = 1'b1;
              else if (s == 0) bits[b] = bus.uart_tx_o;
              else if (bus.uart_tx_o !== bits[b]) ok = 1'b0;
            end
          end
        end
        if (!abort) begin
          chk("bit_width", int'(ok), 1);
          chk("stop_bit", int'(bits[9]), 1);
          rx_log.push_back(bits[8:1]);
          if (exp_b.size() == 0) begin
            chk("rx_unexpected", 1, 0);
          end else begin
            chk("rx_byte", int'(bits[8:1]), int'(exp_b.pop_front()));
            chk("rx_start", t0, exp_t.pop_front());
          end
        end
      end
    end
  end

  initial begin : mon
    logic eb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        eb = (cyc >= busy_start) && (cyc < busy_end);
        if (bus.busy_o !== eb) chk("busy", int'(bus.busy_o), int'(eb));
        if (bus.frame_done_o === 1'b1) begin
          if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
          else chk("done_time", cyc, exp_done.pop_front());
        end else if (exp_done.size() != 0 && exp_done[0] < cyc) begin
          chk("done_missing", cyc, exp_done.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.sample_rdy_i = 1'b0;
    bus.sample_i     = 14'd0;

    idle(2);
    chk("reset_tx", int'(bus.uart_tx_o), 1);
    chk("reset_busy", int'(bus.busy_o), 0);
    chk("reset_done", int'(bus.frame_done_o), 0);
    chk("reset_ovr", int'(bus.overrun_cnt_o), 0);
    #1 rst = 1'b0;
    idle(3);

    pulse(14'h2ABC);
    wait_done();
    chk_log("t1", 8'hD5, 8'h3C);
    chk("t1_ovr", int'(bus.overrun_cnt_o), 0);

    pulse(14'h3FFF);
    wait_done();
    chk_log("t2_max", 8'hFF, 8'h7F);
    pulse(14'h0000);
    wait_done();
    chk_log("t2_min", 8'h80, 8'h00);

    pulse(14'h1234);
    idle(7);
    pulse(14'h0BAD);
    idle(20);
    pulse(14'h3C3C);
    idle(13);
    pulse(14'h2001);
    wait_done();
    chk_log("t3", 8'hA4, 8'h34);
    chk("t3_ovr", int'(bus.overrun_cnt_o), 3);

    pulse(14'h1ABC);
    goto_cyc(busy_start + 3 * C);
    drive(1'b0, 14'd0);
    async_reset();
    idle(4);
    pulse(14'h0F0F);
    wait_done();
    chk_log("t5", 8'h9E, 8'h0F);

    pulse(14'h1111);
    goto_cyc(busy_end);
    drive(1'b1, 14'h2222);
    drive(1'b0, 14'd0);
    goto_cyc(busy_end - 1);
    drive(1'b1, 14'h3333);
    drive(1'b0, 14'd0);
    wait_done();
    chk("t6_len", rx_log.size(), 4);
    if (rx_log.size() == 4) begin
      chk("t6_b2", int'(rx_log[2]), 8'hC4);
      chk("t6_b3", int'(rx_log[3]), 8'h22);
    end
    rx_log.delete();
    chk("t6_ovr", int'(bus.overrun_cnt_o), 1);

    repeat (400) drive(1'b1, 14'($urandom));
    drive(1'b0, 14'd0);
    chk("t4_sat", int'(bus.overrun_cnt_o), 255);
    wait_done();
    idle(50);
    chk("t4_hold", int'(bus.overrun_cnt_o), 255);
    rx_log.delete();
    async_reset();
    chk("t4_clear", int'(bus.overrun_cnt_o), 0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) pulse(14'($urandom));
      else drive(1'b1, 14'($urandom));
      idle($urandom_range(0, 120));
    end
    wait_done();
    chk("rand_ovr", int'(bus.overrun_cnt_o), ovr_m);
    chk("q_bytes_empty", exp_b.size(), 0);
    chk("q_done_empty", exp_done.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
